// File: rtl/l1_data_cache.sv
// rtl/l1_data_cache.sv - direct-mapped write-through no-write-allocate L1 data cache
// Optional hit/miss counters are enabled by defining DCACHE_PERF_COUNTERS_EN.
module l1_data_cache #(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_write_data,
    input  logic [3:0]  cpu_byte_enable,
    input  logic        cpu_write_enable,
    input  logic        cpu_read_enable,
    output logic [31:0] cpu_read_data,
    output logic        stall_cpu,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_byte_enable,
    output logic        mem_write_enable,
    output logic        mem_request,
    input  logic [31:0] mem_read_data,
`ifdef DCACHE_PERF_COUNTERS_EN
    input  logic        mem_ready,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`else
    input  logic        mem_ready
`endif
);

    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int OFF    = 2 + WORD_W;
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = 32 - OFF - IDX_W;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} state_t;

    state_t state, state_next;

    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tags  [NUM_LINES];
    logic [31:0]          words [NUM_LINES*LINE_WORDS];

    logic [31:2]       req_addr;
    logic [31:0]       req_data;
    logic [3:0]        req_be;
    logic [WORD_W-1:0] beat;
    logic              gap;

    logic [IDX_W-1:0]  cpu_idx, req_idx;
    logic [TAG_W-1:0]  cpu_tag, req_tag;
    logic [WORD_W-1:0] cpu_word, req_word;
    logic              cpu_hit, req_hit;
    logic              read_hit;
    logic              beat_accept;
    logic              last_beat;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^cpu_address[1:0];

    assign cpu_idx  = cpu_address[OFF +: IDX_W];
    assign cpu_tag  = cpu_address[31 -: TAG_W];
    assign cpu_word = cpu_address[2 +: WORD_W];
    assign req_idx  = req_addr[OFF +: IDX_W];
    assign req_tag  = req_addr[31 -: TAG_W];
    assign req_word = req_addr[2 +: WORD_W];

    assign cpu_hit = valid[cpu_idx] && (tags[cpu_idx] == cpu_tag);
    assign req_hit = valid[req_idx] && (tags[req_idx] == req_tag);

    assign beat_accept = (state == REFILL) && !gap && mem_ready;
    assign last_beat   = (beat == WORD_W'(LINE_WORDS - 1));

    always_comb begin
        state_next       = state;
        stall_cpu        = 1'b0;
        cpu_read_data    = 32'h0;
        read_hit         = 1'b0;
        mem_address      = 32'h0;
        mem_write_data   = 32'h0;
        mem_byte_enable  = 4'h0;
        mem_write_enable = 1'b0;
        mem_request      = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_write_enable) begin
                    stall_cpu  = 1'b1;
                    state_next = WRITE;
                end else if (cpu_read_enable) begin
                    if (cpu_hit) begin
                        read_hit      = 1'b1;
                        cpu_read_data = words[{cpu_idx, cpu_word}];
                    end else begin
                        stall_cpu  = 1'b1;
                        state_next = REFILL;
                    end
                end
            end
            REFILL: begin
                stall_cpu = 1'b1;
                // One request-low cycle after every beat lets the memory re-arm.
                if (!gap) begin
                    mem_request     = 1'b1;
                    mem_byte_enable = 4'hF;
                    mem_address     = {req_addr[31:OFF], beat, 2'b00};
                    if (mem_ready && last_beat) begin
                        state_next = IDLE;
                    end
                end
            end
            WRITE: begin
                stall_cpu        = 1'b1;
                mem_request      = 1'b1;
                mem_write_enable = 1'b1;
                mem_address      = {req_addr, 2'b00};
                mem_write_data   = req_data;
                mem_byte_enable  = req_be;
                if (mem_ready) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            valid <= '0;
            beat  <= '0;
            gap   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    req_addr <= cpu_address[31:2];
                    req_data <= cpu_write_data;
                    req_be   <= cpu_byte_enable;
                    beat     <= '0;
                    gap      <= 1'b0;
                end
                REFILL: begin
                    if (gap) begin
                        gap <= 1'b0;
                    end else if (mem_ready) begin
                        beat <= beat + 1'b1;
                        gap  <= 1'b1;
                        if (last_beat) begin
                            valid[req_idx] <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Line storage carries no reset; only the valid bits qualify its contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (beat_accept) begin
                words[{req_idx, beat}] <= mem_read_data;
                if (last_beat) begin
                    tags[req_idx] <= req_tag;
                end
            end
            if ((state == WRITE) && mem_ready && req_hit) begin
                for (int b = 0; b < 4; b++) begin
                    if (req_be[b]) begin
                        words[{req_idx, req_word}][8*b +: 8] <= req_data[8*b +: 8];
                    end
                end
            end
        end
    end

`ifdef DCACHE_PERF_COUNTERS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= 32'h0;
            miss_count <= 32'h0;
        end else begin
            if (read_hit) begin
                hit_count <= hit_count + 32'h1;
            end
            if ((state == IDLE) && (state_next == REFILL)) begin
                miss_count <= miss_count + 32'h1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_l1_data_cache.sv
// tb/tb_l1_data_cache.sv - randomized self-checking bench for l1_data_cache against a line-level reference model
module tb_l1_data_cache;

    localparam int NL = 64;
    localparam int LW = 4;
    localparam int LINE_BYTES = LW * 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cpu_address = 32'h0;
    logic [31:0] cpu_write_data = 32'h0;
    logic [3:0]  cpu_byte_enable = 4'h0;
    logic        cpu_write_enable = 1'b0;
    logic        cpu_read_enable = 1'b0;
    logic [31:0] cpu_read_data;
    logic        stall_cpu;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_byte_enable;
    logic        mem_write_enable;
    logic        mem_request;
    logic [31:0] mem_read_data = 32'h0;
    logic        mem_ready = 1'b0;
`ifdef DCACHE_PERF_COUNTERS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    l1_data_cache #(.NUM_LINES(NL), .LINE_WORDS(LW)) dut (
        .clk              (clk),
        .rst              (rst),
        .cpu_address      (cpu_address),
        .cpu_write_data   (cpu_write_data),
        .cpu_byte_enable  (cpu_byte_enable),
        .cpu_write_enable (cpu_write_enable),
        .cpu_read_enable  (cpu_read_enable),
        .cpu_read_data    (cpu_read_data),
        .stall_cpu        (stall_cpu),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_byte_enable  (mem_byte_enable),
        .mem_write_enable (mem_write_enable),
        .mem_request      (mem_request),
        .mem_read_data    (mem_read_data),
`ifdef DCACHE_PERF_COUNTERS_EN
        .mem_ready        (mem_ready),
        .hit_count        (hit_count),
        .miss_count       (miss_count)
`else
        .mem_ready        (mem_ready)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Physical memory (written only by the DUT) and the bench's own expectation of it.
    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] ref_mem   [logic [31:0]];
    bit          ref_valid [NL];
    logic [31:0] ref_tag   [NL];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] phys_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic int line_idx(input logic [31:0] a);
        return int'((a / LINE_BYTES) % NL);
    endfunction

    function automatic bit ref_hit(input logic [31:0] a);
        return ref_valid[line_idx(a)] && (ref_tag[line_idx(a)] == a / (LINE_BYTES * NL));
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] data;
    } beat_t;
    beat_t log_q[$];

    int delay_cfg = 2;
    int cur_delay = 2;
    int cnt = 0;
    logic prev_ready = 1'b0;

    always @(negedge clk) begin
        if (prev_ready) check("gap_after_beat", {31'b0, mem_request}, 32'h0);
        if (!mem_write_enable) check("wdata_zero", mem_write_data, 32'h0);
        if (mem_request && !mem_ready) begin
            if (cnt >= cur_delay) begin
                beat_t e;
                e.addr = mem_address; e.we = mem_write_enable;
                e.be = mem_byte_enable; e.data = mem_write_data;
                log_q.push_back(e);
                mem_ready = 1'b1;
                if (mem_write_enable)
                    mem_model[mem_address] = merge(phys_rd(mem_address), mem_write_data, mem_byte_enable);
                else
                    mem_read_data = phys_rd(mem_address);
            end else begin
                cnt++;
            end
        end else begin
            mem_ready = 1'b0;
            mem_read_data = 32'h0;
            cnt = 0;
            cur_delay = (delay_cfg >= 0) ? delay_cfg : int'($urandom_range(0, 3));
        end
        prev_ready = mem_ready;
    end

    task automatic cpu_read(input logic [31:0] a, input string tag);
        logic [31:0] wa, base, exp_data, got;
        bit exp_miss;
        int cycles, n0;
        wa = a & ~32'h3;
        base = a & ~32'(LINE_BYTES - 1);
        exp_miss = !ref_hit(a);
        exp_data = ref_rd(wa);
        n0 = log_q.size();
        @(posedge clk); #1;
        cpu_address = a;
        cpu_read_enable = 1'b1;
        cycles = 0;
        forever begin
            @(negedge clk);
            if (!stall_cpu) break;
            cycles++;
            if (cycles > 500) begin
                check({tag, "_timeout"}, 32'(cycles), 32'h0);
                break;
            end
        end
        got = cpu_read_data;
        @(posedge clk); #1;
        cpu_read_enable = 1'b0;
        check({tag, "_data"}, got, exp_data);
        check({tag, "_miss"}, {31'b0, cycles != 0}, {31'b0, exp_miss});
        if (exp_miss) begin
            check({tag, "_beats"}, 32'(log_q.size() - n0), 32'(LW));
            for (int i = 0; i < LW && n0 + i < log_q.size(); i++) begin
                check({tag, "_beat_addr"}, log_q[n0 + i].addr, base + 32'(4 * i));
                check({tag, "_beat_rd"}, {28'b0, log_q[n0 + i].we, log_q[n0 + i].be}, 32'hF);
            end
            ref_valid[line_idx(a)] = 1'b1;
            ref_tag[line_idx(a)] = a / (LINE_BYTES * NL);
        end else begin
            check({tag, "_no_mem"}, 32'(log_q.size() - n0), 32'h0);
        end
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input string tag);
        logic [31:0] wa, exp_word;
        int cycles, n0;
        wa = a & ~32'h3;
        exp_word = merge(ref_rd(wa), d, be);
        ref_mem[wa] = exp_word;
        n0 = log_q.size();
        @(posedge clk); #1;
        cpu_address = a;
        cpu_write_data = d;
        cpu_byte_enable = be;
        cpu_write_enable = 1'b1;
        cycles = 0;
        forever begin
            @(negedge clk);
            if (!stall_cpu) break;
            cycles++;
            if (cycles > 500) begin
                check({tag, "_timeout"}, 32'(cycles), 32'h0);
                break;
            end
        end
        @(posedge clk); #1;
        cpu_write_enable = 1'b0;
        check({tag, "_stalled"}, {31'b0, cycles > 0}, 32'h1);
        check({tag, "_beats"}, 32'(log_q.size() - n0), 32'h1);
        if (log_q.size() > n0) begin
            check({tag, "_addr"}, log_q[n0].addr, wa);
            check({tag, "_we"}, {31'b0, log_q[n0].we}, 32'h1);
            check({tag, "_be"}, {28'b0, log_q[n0].be}, {28'b0, be});
            check({tag, "_wdata"}, log_q[n0].data, d);
        end
        check({tag, "_memword"}, phys_rd(wa), exp_word);
    endtask

    initial begin
        int n0, waited;
        logic [31:0] a;
        for (int i = 0; i < NL; i++) begin
            ref_valid[i] = 1'b0;
            ref_tag[i] = 32'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_stall", {31'b0, stall_cpu}, 32'h0);
        check("reset_mem_request", {31'b0, mem_request}, 32'h0);
        check("reset_mem_address", mem_address, 32'h0);
        rst = 1'b0;

        delay_cfg = 2;
        cpu_read(32'h100, "first_refill");
        cpu_read(32'h104, "hit_104");
        cpu_write(32'h108, 32'hAABBCCDD, 4'b0011, "store_108");
        check("store_108_merged", ref_rd(32'h108), {init_word(32'h108) >> 16, 16'hCCDD});
        cpu_read(32'h108, "read_108");
        cpu_write(32'h2000, 32'h0BADF00D, 4'b1111, "store_2000");
        cpu_read(32'h2000, "read_2000");

        cpu_read(32'h100 + 16 * NL, "conflict_pre");
        cpu_read(32'h100, "conflict_a");
        cpu_read(32'h100 + 16 * NL, "conflict_b");
        cpu_read(32'h100, "conflict_c");

        // Reset while beat 2 of a refill is on the bus.
        n0 = log_q.size();
        @(posedge clk); #1;
        cpu_address = 32'h3000;
        cpu_read_enable = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            if (log_q.size() - n0 == 3 && mem_request) break;
            waited++;
            if (waited > 200) begin
                check("rst_wait_timeout", 32'(waited), 32'h0);
                break;
            end
        end
        rst = 1'b1;
        cpu_read_enable = 1'b0;
        @(negedge clk);
        check("rst_mid_mem_request", {31'b0, mem_request}, 32'h0);
        check("rst_mid_stall", {31'b0, stall_cpu}, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < NL; i++) ref_valid[i] = 1'b0;
        cpu_read(32'h3000, "reread_3000");
        cpu_read(32'h100, "reread_100");

        delay_cfg = -1;
        for (int k = 0; k < 200; k++) begin
            a = 32'($urandom_range(0, 3)) * 32'(LINE_BYTES * NL)
              + 32'($urandom_range(0, 7)) * 32'(LINE_BYTES)
              + 32'($urandom_range(0, LW - 1)) * 32'd4
              + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0)
                cpu_write(a, $urandom, 4'($urandom_range(1, 15)), "rnd_wr");
            else
                cpu_read(a, "rnd_rd");
        end

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/l1_data_cache.md
Name: l1_data_cache

Overview:
- Direct-mapped, write-through, no-write-allocate L1 data cache.
- Sits between the core's load/store port and the data port (port B) of the unified main memory.
- Read hits complete combinationally with no stall.
- Read misses refill a whole line word-by-word over a request/ready memory handshake. Writes are forwarded to memory one word at a time.

Parameters:
- NUM_LINES, 64: number of cache lines; power of two.
- LINE_WORDS, 4: 32-bit words per line; power of two, at least 2.

Ports:
- clk  in  1  clock; everything is sampled on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_address  in  32  byte address from the core; bits [1:0] are ignored for cache lookup.
- cpu_write_data  in  32  store data.
- cpu_byte_enable  in  4  store byte lanes.
- cpu_write_enable  in  1  store request.
- cpu_read_enable  in  1  load request.
- cpu_read_data  out  32  load data (combinational).
- stall_cpu  out  1  core must hold its request while this is high (combinational).
- mem_address  out  32  word-aligned memory address.
- mem_write_data  out  32  memory write data.
- mem_byte_enable  out  4  memory byte lanes.
- mem_write_enable  out  1  memory write strobe.
- mem_request  out  1  memory transaction active.
- mem_read_data  in  32  memory read data; valid while mem_ready=1.
- mem_ready  in  1  beat complete.

Behaviour:
- Address split:
  - offset = addr[OFF-1:0], with OFF = 2 + log2(LINE_WORDS).
  - index = next log2(NUM_LINES) bits.
  - tag = the remaining upper bits.
- Storage: valid bit, tag and LINE_WORDS data words per line. Only the valid bits are reset.
- States: IDLE, REFILL, WRITE, DONE.
- IDLE, write request (cpu_write_enable=1):
  - Write has priority if read and write are both requested.
  - stall_cpu=1 combinationally.
  - Next state is WRITE. Latch address, data and byte enables.
- IDLE, read request:
  - Hit (valid and tag match): stall_cpu=0; cpu_read_data = the addressed word.
  - Miss: stall_cpu=1; next state is REFILL with beat=0.
- IDLE, no request: stall_cpu=0; all mem_* outputs are 0.
- REFILL:
  - mem_request=1, mem_write_enable=0, mem_byte_enable=4'hF.
  - mem_address = line base + 4*beat.
  - A beat is accepted on an edge where mem_request=1 and mem_ready=1: store mem_read_data into word[beat].
  - After each accepted beat, mem_request is low for exactly one cycle before the next beat's address is presented. This lets the memory latency counter re-arm.
  - On the final beat, set the valid bit and tag, then go to IDLE. The retried read then hits.
  - stall_cpu=1 throughout.
- WRITE:
  - mem_request=1, mem_write_enable=1.
  - mem_address = latched word-aligned address; mem_write_data and mem_byte_enable = latched values.
  - Hold until mem_ready=1. On that edge:
    - if the line hits, merge the enabled bytes into the cached word (a miss does not allocate);
    - go to DONE.
  - stall_cpu=1 throughout.
- DONE:
  - stall_cpu=0 for one cycle so the core retires the store; mem_request=0.
  - No new access is started in this cycle.
  - Next state is IDLE.
- mem_write_data=0 whenever mem_write_enable=0.
- Reset, including mid-refill or mid-write:
  - state IDLE, all valid bits cleared, beat counter 0.
  - mem_request=0 and stall_cpu=0 in the cycle after reset.
  - A partially refilled line stays invalid.
- A change of cpu_address while stall_cpu=1 is illegal; the cache uses the latched or original request.

Optional Feature:
- Macro DCACHE_PERF_COUNTERS_EN, when defined:
  - adds 32-bit outputs hit_count and miss_count, both cleared by rst;
  - hit_count increments on each IDLE read hit with stall_cpu=0;
  - miss_count increments on each IDLE-to-REFILL transition;
  - both wrap at 2^32.
- When the macro is undefined, these ports and the counter logic do not exist.

Test Plan:
- Reset, then read 0x100 with memory word 0x100=0xDEADBEEF and a 2-cycle ready delay:
  - 4 beats at addresses 0x100, 0x104, 0x108, 0x10C, each separated by a request-low cycle;
  - then stall_cpu=0 with cpu_read_data=0xDEADBEEF.
- Read 0x104 immediately afterwards → stall_cpu=0 in the same cycle; no mem_request.
- Store 0xAABBCCDD with byte enable 4'b0011 to 0x108 (cached line):
  - one memory write with mem_byte_enable=4'b0011, then one DONE cycle;
  - a later read of 0x108 returns the old upper half with 0xCCDD in the low half, without a miss.
- Store to uncached 0x2000 → memory write only; a later read of 0x2000 misses and refills.
- Conflict: read 0x100, then 0x100 + 16*NUM_LINES, then 0x100 → three refills.
- Assert rst during beat 2 of a refill → next cycle mem_request=0 and stall_cpu=0; a re-read of the line misses.
